// File: rtl/hweval_pkg.sv
// rtl/hweval_pkg.sv - shared FSM state encoding and signature helpers for the evaluation controller
package hweval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    UPDATE,
    DONE
  } state_t;

  // Rotate the low w bits of x left by one; bits above w are returned as zero.
  function automatic logic [63:0] rotl1(input logic [63:0] x, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x << 1) | (x >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/hweval_sig_fold.sv
// rtl/hweval_sig_fold.sv - XOR of all SIG_W-wide slices of a WIDTH-wide word
module hweval_sig_fold #(
  parameter int WIDTH = 512,
  parameter int SIG_W = 32
) (
  input  logic [WIDTH-1:0] data,
  output logic [SIG_W-1:0] folded
);

  always_comb begin
    folded = '0;
    for (int i = 0; i < WIDTH / SIG_W; i++) begin
      folded = folded ^ data[i*SIG_W +: SIG_W];
    end
  end

endmodule

// File: rtl/montgomery_hweval_ctrl.sv
// rtl/montgomery_hweval_ctrl.sv - chained-multiply self-check controller for an external Montgomery core
// Optional max_latency statistics port enabled by HWEVAL_LATENCY_STATS_EN.
module montgomery_hweval_ctrl
  import hweval_pkg::*;
#(
  parameter int               WIDTH       = 512,
  parameter int               SIG_W       = 32,
  parameter int               ITERATIONS  = 16,
  parameter int               TIMEOUT_CYC = 4096,
  parameter logic [WIDTH-1:0] A_SEED      = WIDTH'(1),
  parameter logic [WIDTH-1:0] B_SEED      = WIDTH'(1),
  parameter logic [WIDTH-1:0] M_VAL       = '0,
  parameter logic [SIG_W-1:0] EXP_SIG     = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 go,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic                                 fail,
  output logic                                 timeout,
  output logic [$clog2(ITERATIONS+1)-1:0]      iter_count,
  output logic [SIG_W-1:0]                     signature,
  output logic                                 mm_start,
  output logic [WIDTH-1:0]                     mm_a,
  output logic [WIDTH-1:0]                     mm_b,
  output logic [WIDTH-1:0]                     mm_m,
  input  logic [WIDTH-1:0]                     mm_result,
  input  logic                                 mm_done
`ifdef HWEVAL_LATENCY_STATS_EN
  ,
  output logic [$clog2(TIMEOUT_CYC+1)-1:0]     max_latency
`endif
);

  localparam int IW = $clog2(ITERATIONS + 1);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITERATIONS - 1);

  state_t            state, state_n;
  logic [CW-1:0]     wait_cnt;
  logic [CW-1:0]     wait_inc;
  logic [WIDTH-1:0]  res_q;
  logic [SIG_W-1:0]  folded;
  logic [SIG_W-1:0]  sig_n;
  logic              timeout_hit;
  logic              last_iter;

  hweval_sig_fold #(.WIDTH(WIDTH), .SIG_W(SIG_W)) u_fold (
    .data   (res_q),
    .folded (folded)
  );

  assign wait_inc  = wait_cnt + 1'b1;
  assign sig_n     = SIG_W'(rotl1(64'(signature), SIG_W)) ^ folded;
  assign last_iter = (iter_count == ITER_LAST);

  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE, DONE: if (go) state_n = START;
      START:      state_n = WAIT;
      WAIT: begin
        // A completion arriving on the watchdog's last cycle still counts.
        if (mm_done) begin
          state_n = UPDATE;
        end else if (wait_inc == TO_LIM) begin
          state_n     = DONE;
          timeout_hit = 1'b1;
        end
      end
      UPDATE:     state_n = last_iter ? DONE : START;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      mm_start   <= 1'b0;
      iter_count <= '0;
      signature  <= '0;
      mm_a       <= A_SEED;
      mm_b       <= B_SEED;
      mm_m       <= M_VAL;
      wait_cnt   <= '0;
      res_q      <= '0;
`ifdef HWEVAL_LATENCY_STATS_EN
      max_latency <= '0;
`endif
    end else begin
      state    <= state_n;
      mm_start <= (state_n == START);
      busy     <= (state_n == START) || (state_n == WAIT) || (state_n == UPDATE);
      done     <= (state_n == DONE);
      mm_m     <= M_VAL;
      case (state)
        IDLE, DONE: begin
          if (go) begin
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            iter_count <= '0;
            signature  <= '0;
            mm_a       <= A_SEED;
            mm_b       <= B_SEED;
`ifdef HWEVAL_LATENCY_STATS_EN
            max_latency <= '0;
`endif
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_inc;
          if (mm_done) begin
            res_q <= mm_result;
`ifdef HWEVAL_LATENCY_STATS_EN
            if (wait_inc > max_latency) max_latency <= wait_inc;
`endif
          end else if (timeout_hit) begin
            timeout <= 1'b1;
            fail    <= 1'b1;
            pass    <= 1'b0;
          end
        end
        UPDATE: begin
          mm_a       <= mm_b ^ res_q;
          mm_b       <= res_q;
          iter_count <= iter_count + 1'b1;
          signature  <= sig_n;
          if (last_iter) begin
            pass <= (sig_n == EXP_SIG);
            fail <= (sig_n != EXP_SIG);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_hweval_ctrl.sv
// tb/tb_montgomery_hweval_ctrl.sv - scoreboard bench with stub multiplier; checks max_latency when HWEVAL_LATENCY_STATS_EN is defined
module tb_montgomery_hweval_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        busy, done, pass, fail, timeout;
  logic [2:0]  iter_count;
  logic [15:0] signature;
  logic        mm_start;
  logic [15:0] mm_a, mm_b, mm_m;
  logic [15:0] mm_result;
  logic        mm_done;
`ifdef HWEVAL_LATENCY_STATS_EN
  logic [4:0]  max_latency;
`endif

  montgomery_hweval_ctrl #(
    .WIDTH(16), .SIG_W(16), .ITERATIONS(4), .TIMEOUT_CYC(16),
    .A_SEED(16'h0001), .B_SEED(16'h0001), .M_VAL(16'h00A5), .EXP_SIG(16'h0011)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .iter_count(iter_count), .signature(signature),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
`ifdef HWEVAL_LATENCY_STATS_EN
    , .max_latency(max_latency)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          t;
  } op_t;

  op_t         exp_q[$];
  int          lat_q[$];
  int          cyc = 0;
  int          g = 0;
  int          rem = 0;
  int          start_cnt = 0;
  logic [15:0] stub_res = 16'h0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Stub multiplier and operand monitor: constant result, per-op latency from lat_q (0 = never completes).
  initial begin
    mm_done   = 1'b0;
    mm_result = 16'h0;
    forever @(negedge clk) begin
      op_t e;
      mm_done = 1'b0;
      if (reset) begin
        rem = 0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            mm_done   = 1'b1;
            mm_result = stub_res;
          end
        end
        if (mm_start) begin
          start_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_start", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("start_cycle", 64'(cyc - g + 1), 64'(e.t));
            check("mm_a", mm_a, e.a);
            check("mm_b", mm_b, e.b);
            check("mm_m", mm_m, 16'h00A5);
          end
          rem = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end
      end
    end
  end

  task automatic do_run(input logic [15:0] res, input int l0, input int l1, input int l2,
                        input int l3, input bit never, input int go_mid, input int reset_at);
    logic [15:0] a, b, sig, an;
    int lat[4];
    int t, mx, rel, k;
    lat = '{l0, l1, l2, l3};
    a = 16'h1; b = 16'h1; sig = 16'h0; t = 1; mx = 0;
    exp_q.delete();
    lat_q.delete();
    stub_res  = res;
    start_cnt = 0;
    if (never) begin
      exp_q.push_back('{a: 16'h1, b: 16'h1, t: 1});
      lat_q.push_back(0);
      t = 18;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{a: a, b: b, t: t});
        lat_q.push_back(lat[i]);
        t += lat[i] + 2;
        if (lat[i] > mx) mx = lat[i];
        an  = b ^ res;
        b   = res;
        a   = an;
        sig = {sig[14:0], sig[15]} ^ res;
      end
    end
    @(negedge clk);
    go = 1'b1;
    g  = cyc + 1;
    @(negedge clk);
    go = 1'b0;
    check("go_done_clr", done, 0);
    check("go_busy", busy, 1);
    check("go_iter_clr", iter_count, 0);
    check("go_sig_clr", signature, 0);
`ifdef HWEVAL_LATENCY_STATS_EN
    check("go_maxlat_clr", max_latency, 0);
`endif
    for (k = 0; k < 200 && !done; k++) begin
      rel = cyc - g + 1;
      go  = (rel == go_mid);
      if (rel == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_mm_start", mm_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_iter", iter_count, 0);
        check("rst_sig", signature, 0);
        check("rst_mm_a", mm_a, 16'h1);
        check("rst_mm_b", mm_b, 16'h1);
        check("rst_flags", {pass, fail, timeout}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    go = 1'b0;
    if (!done) begin
      check("done_wait_expired", 0, 1);
      return;
    end
    check("done_cycle", 64'(cyc - g + 1), 64'(t));
    check("busy_at_done", busy, 0);
    check("iter_count", iter_count, never ? 0 : 4);
    check("signature", signature, sig);
    check("pass", pass, !never && (sig == 16'h0011));
    check("fail", fail, never || (sig != 16'h0011));
    check("timeout", timeout, never);
    check("starts", start_cnt, never ? 1 : 4);
    check("sb_empty", exp_q.size(), 0);
`ifdef HWEVAL_LATENCY_STATS_EN
    check("max_latency", max_latency, mx);
`endif
    repeat (5) @(negedge clk);
    check("done_hold", done, 1);
    check("no_extra_start", start_cnt, never ? 1 : 4);
  endtask

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_flags", {pass, fail, timeout, mm_start}, 4'b0000);
    check("reset_iter", iter_count, 0);
    check("reset_sig", signature, 0);
    check("reset_ops", {mm_a, mm_b, mm_m}, {16'h1, 16'h1, 16'h00A5});
`ifdef HWEVAL_LATENCY_STATS_EN
    check("reset_maxlat", max_latency, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    do_run(16'h0003, 5, 5, 5, 5, 1'b0, 3, 0);
    do_run(16'h0005, 5, 5, 5, 5, 1'b0, 0, 0);
    do_run(16'h0003, 3, 7, 5, 4, 1'b0, 0, 0);
    do_run(16'h0003, 0, 0, 0, 0, 1'b1, 0, 0);
    do_run(16'h0003, 5, 5, 5, 5, 1'b0, 0, 10);
    do_run(16'h0003, 5, 5, 5, 5, 1'b0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
